// File: rtl/ir_nec_tx_if.sv
// Request/status bundle for the NEC infrared transmitter (ir_nec_tx).
// The master side issues frames and the slave side is the transmitter.
interface ir_nec_tx_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_addr;
  logic [7:0] tx_cmd;
  logic       tx_hold;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_valid, tx_addr, tx_cmd, tx_hold,
    input  tx_ready, tx_busy, tx_done
  );

  modport slave (
    input  tx_valid, tx_addr, tx_cmd, tx_hold,
    output tx_ready, tx_busy, tx_done
  );
endinterface

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: serialises {~cmd, cmd, ~addr, addr} LSB-first as a
// 38 kHz modulated frame. Define IR_REPEAT_EN to emit repeat codes while tx_hold=1.
module ir_nec_tx #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 439,
  parameter int FRAME_UNITS  = 192
) (
  input  logic         CLOCK_50,
  input  logic         rst,
  ir_nec_tx_if.slave   tx,
  output logic         IRDA_TXD,
  output logic         ir_env
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int CW = $clog2(CARRIER_DIV + 1);
  localparam int FW = (FRAME_UNITS > 1) ? $clog2(FRAME_UNITS) : 1;

  typedef enum logic [3:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
`ifdef IR_REPEAT_EN
    ,
    RPT_MARK,
    RPT_SPACE,
    RPT_STOP
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [UW-1:0]   ucnt, ucnt_nxt;
  logic [4:0]      ncnt, ncnt_nxt;
  logic [FW-1:0]   fcnt, fcnt_nxt;
  logic [CW-1:0]   ccnt, ccnt_nxt;
  logic [4:0]      bitcnt, bitcnt_nxt;
  logic [31:0]     shreg, shreg_nxt;
  logic            done_q, done_nxt;
  logic            env_q, txd_q;
  logic            unit_tick;
  logic            mark_nxt;

  function automatic logic is_mark(input state_t s);
    case (s)
      LEAD_MARK, BIT_MARK, STOP_MARK: is_mark = 1'b1;
`ifdef IR_REPEAT_EN
      RPT_MARK, RPT_STOP:             is_mark = 1'b1;
`endif
      default:                        is_mark = 1'b0;
    endcase
  endfunction

  assign unit_tick = (ucnt == UW'(UNIT_CYCLES - 1));

  always_comb begin
    state_nxt  = state;
    ucnt_nxt   = ucnt;
    ncnt_nxt   = ncnt;
    fcnt_nxt   = fcnt;
    bitcnt_nxt = bitcnt;
    shreg_nxt  = shreg;
    done_nxt   = 1'b0;
    ccnt_nxt   = (ccnt == CW'(CARRIER_DIV - 1)) ? '0 : ccnt + 1'b1;

    // The unit timer free-runs across state changes so every unit stays aligned to accept.
    if (state != IDLE) begin
      ucnt_nxt = unit_tick ? '0 : ucnt + 1'b1;
      if (unit_tick) begin
        ncnt_nxt = ncnt + 1'b1;
        fcnt_nxt = fcnt + 1'b1;
      end
    end

    case (state)
      IDLE: begin
        ucnt_nxt = '0;
        if (tx.tx_valid) begin
          state_nxt  = LEAD_MARK;
          shreg_nxt  = {~tx.tx_cmd, tx.tx_cmd, ~tx.tx_addr, tx.tx_addr};
          fcnt_nxt   = '0;
          bitcnt_nxt = '0;
        end
      end
      LEAD_MARK:
        if (unit_tick && ncnt == 5'd15) state_nxt = LEAD_SPACE;
      LEAD_SPACE:
        if (unit_tick && ncnt == 5'd7) state_nxt = BIT_MARK;
      BIT_MARK:
        if (unit_tick && ncnt == 5'd0) state_nxt = BIT_SPACE;
      BIT_SPACE:
        if (unit_tick && ncnt == (shreg[0] ? 5'd2 : 5'd0)) begin
          shreg_nxt  = {1'b0, shreg[31:1]};
          bitcnt_nxt = bitcnt + 1'b1;
          state_nxt  = (bitcnt == 5'd31) ? STOP_MARK : BIT_MARK;
        end
      STOP_MARK:
        if (unit_tick) begin
          state_nxt = GAP;
          done_nxt  = 1'b1;
        end
      GAP:
        if (unit_tick && fcnt == FW'(FRAME_UNITS - 1)) begin
`ifdef IR_REPEAT_EN
          if (tx.tx_hold) begin
            state_nxt = RPT_MARK;
            fcnt_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end
`ifdef IR_REPEAT_EN
      RPT_MARK:
        if (unit_tick && ncnt == 5'd15) state_nxt = RPT_SPACE;
      RPT_SPACE:
        if (unit_tick && ncnt == 5'd3) state_nxt = RPT_STOP;
      RPT_STOP:
        if (unit_tick && ncnt == 5'd0) state_nxt = GAP;
`endif
      default: state_nxt = IDLE;
    endcase

    // Carrier phase restarts on every mark entry so the first pulse is full width.
    if (state_nxt != state) ncnt_nxt = '0;
    if (state_nxt != state || !is_mark(state_nxt)) ccnt_nxt = '0;
  end

  assign mark_nxt = is_mark(state_nxt);

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state  <= IDLE;
      ucnt   <= '0;
      ncnt   <= '0;
      fcnt   <= '0;
      ccnt   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      done_q <= 1'b0;
      env_q  <= 1'b0;
      txd_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      ucnt   <= ucnt_nxt;
      ncnt   <= ncnt_nxt;
      fcnt   <= fcnt_nxt;
      ccnt   <= ccnt_nxt;
      bitcnt <= bitcnt_nxt;
      shreg  <= shreg_nxt;
      done_q <= done_nxt;
      env_q  <= mark_nxt;
      txd_q  <= mark_nxt && (ccnt_nxt < CW'(CARRIER_HIGH));
    end
  end

`ifndef IR_REPEAT_EN
  logic unused_hold;
  assign unused_hold = tx.tx_hold;
`endif

  assign tx.tx_ready = (state == IDLE);
  assign tx.tx_busy  = (state != IDLE);
  assign tx.tx_done  = done_q;
  assign IRDA_TXD    = txd_q;
  assign ir_env      = env_q;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Directed bench for ir_nec_tx with a shortened unit time; decodes the envelope
// back into bits and checks carrier shape, tx_done/tx_ready timing and reset.
module tb_ir_nec_tx;

  localparam int U     = 20;
  localparam int CDIV  = 7;
  localparam int CHIGH = 3;
  localparam int FU    = 192;
  localparam int MAXK  = 8000;

  logic CLOCK_50 = 1'b0;
  logic rst      = 1'b0;
  logic IRDA_TXD;
  logic ir_env;

  ir_nec_tx_if bus ();

  ir_nec_tx #(
    .UNIT_CYCLES  (U),
    .CARRIER_DIV  (CDIV),
    .CARRIER_HIGH (CHIGH),
    .FRAME_UNITS  (FU)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .tx       (bus),
    .IRDA_TXD (IRDA_TXD),
    .ir_env   (ir_env)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic env_s [1:MAXK];
  int   txd_err, busy_err, done_cnt, done_k, ready_k;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int run_len(input int start, input int last);
    int   n = 0;
    logic v = env_s[start];
    for (int k = start; k <= last; k++) begin
      if (env_s[k] !== v) break;
      n++;
    end
    return n;
  endfunction

  task automatic send(input logic [7:0] a, input logic [7:0] c);
    @(negedge CLOCK_50);
    bus.tx_addr  = a;
    bus.tx_cmd   = c;
    bus.tx_valid = 1'b1;
    @(posedge CLOCK_50);
    #1;
    bus.tx_valid = 1'b0;
  endtask

  // Sample k is taken on the falling edge after the k-th rising edge past accept.
  task automatic watch(input int ncyc, input int inject_k, input int hold_drop_k);
    int   mpos;
    logic prev, exp_txd;
    txd_err = 0; busy_err = 0; done_cnt = 0; done_k = -1; ready_k = -1;
    prev = 1'b0; mpos = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge CLOCK_50);
      if (k == inject_k) begin
        bus.tx_valid = 1'b1;
        bus.tx_addr  = 8'hAA;
        bus.tx_cmd   = 8'h55;
      end
      if (k == inject_k + 3) bus.tx_valid = 1'b0;
      if (k == hold_drop_k) bus.tx_hold = 1'b0;
      env_s[k] = ir_env;
      mpos     = (ir_env && prev) ? mpos + 1 : 0;
      exp_txd  = ir_env && ((mpos % CDIV) < CHIGH);
      if (IRDA_TXD !== exp_txd) txd_err++;
      if (bus.tx_busy !== ~bus.tx_ready) busy_err++;
      if (bus.tx_done === 1'b1) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (bus.tx_ready === 1'b1 && ready_k < 0) ready_k = k;
      prev = ir_env;
    end
  endtask

  task automatic check_frame(input logic [31:0] exp_word, input int last, output int p);
    int m, s, terr;
    logic [31:0] word;
    terr = 0; word = '0; p = 1;
    check_eq("lead_mark_level", 32'(env_s[1]), 32'd1);
    m = run_len(p, last); check_eq("lead_mark_len", m, 16*U); p += m;
    s = run_len(p, last); check_eq("lead_space_len", s, 8*U); p += s;
    for (int i = 0; i < 32; i++) begin
      m = run_len(p, last); p += m;
      s = run_len(p, last); p += s;
      if (m != U || (s != U && s != 3*U)) terr++;
      word[i] = (s > 2*U);
    end
    check_eq("bit_timing_errs", terr, 0);
    check_eq("frame_word", word, exp_word);
    m = run_len(p, last); check_eq("stop_mark_len", m, U); p += m;
    check_eq("data_end_pos", p, 121*U + 1);
  endtask

  initial begin
    int p, nw;
    bus.tx_valid = 1'b0;
    bus.tx_addr  = '0;
    bus.tx_cmd   = '0;
    bus.tx_hold  = 1'b0;

    // Reset
    rst = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_eq("rst_txd",   32'(IRDA_TXD),     32'd0);
    check_eq("rst_env",   32'(ir_env),       32'd0);
    check_eq("rst_ready", 32'(bus.tx_ready), 32'd1);
    check_eq("rst_busy",  32'(bus.tx_busy),  32'd0);
    check_eq("rst_done",  32'(bus.tx_done),  32'd0);
    rst = 1'b0;

    // Frame 00/16 with a mid-frame request that must be ignored
    nw = FU*U + 201;
    send(8'h00, 8'h16);
    watch(nw, 1000, 0);
    check_frame(32'hE916FF00, nw, p);
    check_eq("f1_tail_quiet", run_len(p, nw), nw - 121*U);
    check_eq("f1_done_pos",   done_k,   121*U + 1);
    check_eq("f1_done_cnt",   done_cnt, 1);
    check_eq("f1_ready_pos",  ready_k,  FU*U + 1);
    check_eq("f1_txd_errs",   txd_err,  0);
    check_eq("f1_busy_errs",  busy_err, 0);

    // Reset during LEAD_SPACE
    send(8'h5A, 8'hC3);
    repeat (19*U) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check_eq("mid_env_space", 32'(ir_env), 32'd0);
    check_eq("mid_busy",      32'(bus.tx_busy), 32'd1);
    rst = 1'b1;
    @(posedge CLOCK_50);
    #1;
    rst = 1'b0;
    check_eq("mid_rst_ready", 32'(bus.tx_ready), 32'd1);
    check_eq("mid_rst_env",   32'(ir_env),       32'd0);
    check_eq("mid_rst_txd",   32'(IRDA_TXD),     32'd0);

    // rst and tx_valid on the same edge: nothing latched
    @(negedge CLOCK_50);
    rst = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_addr  = 8'h77;
    @(posedge CLOCK_50);
    #1;
    rst = 1'b0;
    bus.tx_valid = 1'b0;
    check_eq("rstv_ready", 32'(bus.tx_ready), 32'd1);
    @(posedge CLOCK_50);
    #1;
    check_eq("rstv_env", 32'(ir_env), 32'd0);

    // Full frame after reset recovery
    nw = FU*U + 1;
    send(8'h81, 8'h3C);
    watch(nw, 0, 0);
    check_frame(32'hC33C7E81, nw, p);
    check_eq("f3_done_pos",  done_k,   121*U + 1);
    check_eq("f3_ready_pos", ready_k,  FU*U + 1);
    check_eq("f3_txd_errs",  txd_err,  0);

    // Held key
    nw = 2*FU*U + 1;
    bus.tx_hold = 1'b1;
    send(8'h10, 8'h08);
    watch(nw, 0, FU*U + 50);
    check_frame(32'hF708EF10, nw, p);
    check_eq("h_done_cnt",  done_cnt, 1);
    check_eq("h_txd_errs",  txd_err,  0);
    check_eq("h_busy_errs", busy_err, 0);
`ifdef IR_REPEAT_EN
    check_eq("h_gap_len",     run_len(p, nw), 71*U);
    p += 71*U;
    check_eq("h_rpt_mark",    run_len(p, nw), 16*U);
    p += 16*U;
    check_eq("h_rpt_space",   run_len(p, nw), 4*U);
    p += 4*U;
    check_eq("h_rpt_stop",    run_len(p, nw), U);
    p += U;
    check_eq("h_tail_quiet",  run_len(p, nw), nw - p + 1);
    check_eq("h_ready_pos",   ready_k, 2*FU*U + 1);
`else
    check_eq("h_tail_quiet",  run_len(p, nw), nw - 121*U);
    check_eq("h_ready_pos",   ready_k, FU*U + 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
